// File: rtl/fpu_pkg.sv
// Shared encodings for the FP issue path: op and precision codes and the issue FSM states.
package fpu_pkg;

    localparam logic FPU_OP_ADD      = 1'b0;
    localparam logic FPU_OP_MUL      = 1'b1;
    localparam logic FPU_PREC_HALF   = 1'b0;
    localparam logic FPU_PREC_SINGLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fpu.sv
// Combinational add/mul for half and single precision. Subnormals flush to zero, rounding
// truncates, overflow saturates to infinity; NaN/Inf inputs are not given special treatment.
module fp_core #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           i_mul,
    input  logic [EW+MW:0] i_a,
    input  logic [EW+MW:0] i_b,
    output logic [EW+MW:0] o_res
);

    localparam int W    = EW + MW + 1;
    localparam int MF   = MW + 1;
    localparam int GW   = MF + 2;
    localparam int E    = MF + GW;
    localparam int P2   = 2 * MF;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;

    logic          w_sa, w_sb;
    logic [EW-1:0] w_ea, w_eb;
    logic [MF-1:0] w_fa, w_fb;

    assign w_sa = i_a[W-1];
    assign w_sb = i_b[W-1];
    assign w_ea = i_a[W-2 -: EW];
    assign w_eb = i_b[W-2 -: EW];
    assign w_fa = (w_ea == '0) ? '0 : {1'b1, i_a[MW-1:0]};
    assign w_fb = (w_eb == '0) ? '0 : {1'b1, i_b[MW-1:0]};

    function automatic logic [W-1:0] pack(input logic s, input int e, input logic [MW-1:0] m);
        if (e >= EMAX) return {s, {EW{1'b1}}, {MW{1'b0}}};
        if (e <= 0)    return {s, {(W-1){1'b0}}};
        return {s, EW'(e), m};
    endfunction

    logic          w_swap, w_sg;
    logic [EW-1:0] w_eg, w_el;
    logic [MF-1:0] w_fg, w_fl;
    logic [E-1:0]  w_xl, w_mask, w_sh;
    logic [E:0]    w_sum, w_norm;
    int            w_d, w_p;
    logic [W-1:0]  w_add;

    // Smaller operand is aligned with a sticky LSB so truncation of a difference stays exact.
    always_comb begin
        w_swap = {w_eb, w_fb} > {w_ea, w_fa};
        w_sg   = w_swap ? w_sb : w_sa;
        w_eg   = w_swap ? w_eb : w_ea;
        w_el   = w_swap ? w_ea : w_eb;
        w_fg   = w_swap ? w_fb : w_fa;
        w_fl   = w_swap ? w_fa : w_fb;
        w_d    = int'(w_eg) - int'(w_el);
        if (w_d > E) w_d = E;
        w_xl   = {w_fl, {GW{1'b0}}};
        w_mask = (E'(1) << w_d) - E'(1);
        w_sh   = (w_xl >> w_d) | {{(E-1){1'b0}}, |(w_xl & w_mask)};
        w_sum  = (w_sa == w_sb) ? {1'b0, w_fg, {GW{1'b0}}} + {1'b0, w_sh}
                                : {1'b0, w_fg, {GW{1'b0}}} - {1'b0, w_sh};
        w_p    = 0;
        for (int i = 0; i <= E; i++) if (w_sum[i]) w_p = i;
        w_norm = w_sum << (E - w_p);
        w_add  = (w_sum == '0) ? '0 : pack(w_sg, int'(w_eg) + w_p - (E - 1), w_norm[E-1 -: MW]);
    end

    logic [P2-1:0] w_prod;
    logic [MW-1:0] w_mm;
    int            w_em;
    logic [W-1:0]  w_mul;

    always_comb begin
        w_prod = P2'(w_fa) * P2'(w_fb);
        w_em   = int'(w_ea) + int'(w_eb) - BIAS + int'(w_prod[P2-1]);
        w_mm   = w_prod[P2-1] ? w_prod[P2-2 -: MW] : w_prod[P2-3 -: MW];
        w_mul  = (w_fa == '0 || w_fb == '0) ? {w_sa ^ w_sb, {(W-1){1'b0}}}
                                            : pack(w_sa ^ w_sb, w_em, w_mm);
    end

    logic w_unused;
    assign w_unused = ^{w_norm[E], w_norm[E-MW-1:0], w_prod[MW-1:0]};

    assign o_res = i_mul ? w_mul : w_add;

endmodule

module fpu
    import fpu_pkg::*;
(
    input  logic        i_op,
    input  logic        i_prec,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res
);

    logic [15:0] w_half;
    logic [31:0] w_single;

    fp_core #(.EW(5), .MW(10)) u_half (
        .i_mul (i_op == FPU_OP_MUL),
        .i_a   (i_a[15:0]),
        .i_b   (i_b[15:0]),
        .o_res (w_half)
    );

    fp_core #(.EW(8), .MW(23)) u_single (
        .i_mul (i_op == FPU_OP_MUL),
        .i_a   (i_a),
        .i_b   (i_b),
        .o_res (w_single)
    );

    assign o_res = (i_prec == FPU_PREC_HALF) ? {16'h0, w_half} : w_single;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above the pointer, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PW-1:0]      o_idx,
    output logic               o_any
);

    always_comb begin
        logic found;
        int   idx;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!found && i_req[PW'(idx)]) begin
                found             = 1'b1;
                o_gnt[PW'(idx)]   = 1'b1;
                o_idx             = PW'(idx);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared combinational fpu, one op in flight,
// operands held for LATENCY cycles before the result is captured onto a tagged response.
module fpu_issue_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 2,
    parameter int ID_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ-1:0]    req_prec,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    localparam int         PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t            r_state, w_next;
    logic [PW-1:0]     r_ptr;
    logic [3:0]        r_cnt;
    logic              r_op, r_prec;
    logic [31:0]       r_a, r_b, r_data;
    logic [ID_W-1:0]   r_id, r_rsp_id;

    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic               w_sel_op, w_sel_prec;
    logic [31:0]        w_sel_a, w_sel_b, w_fpu_res;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_op   = 1'b0;
        w_sel_prec = 1'b0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == PW'(i)) begin
                w_sel_op   = req_op[i];
                w_sel_prec = req_prec[i];
                w_sel_a    = req_a[i*32 +: 32];
                w_sel_b    = req_b[i*32 +: 32];
            end
        end
    end

    fpu u_fpu (
        .i_op   (r_op),
        .i_prec (r_prec),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_res  (w_fpu_res)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = EXEC;
            EXEC:    if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_prec   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_rsp_id <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_op   <= w_sel_op;
                    r_prec <= w_sel_prec;
                    r_a    <= w_sel_a;
                    r_b    <= w_sel_b;
                    r_id   <= ID_W'(w_idx);
                    r_cnt  <= '0;
                    r_ptr  <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);
                end
                EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    // Response registers only move here, so they stay put through DONE.
                    if (r_cnt == CNT_LAST) begin
                        r_data   <= w_fpu_res;
                        r_rsp_id <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign rsp_valid = (r_state == DONE);
    assign rsp_data  = r_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

endmodule
